sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Sequential consumer of the sprite ROMs: walks a 21×21 sprite image through a ROM's `read_address`/`output_color` port and writes the resulting pixels into the 640×480 frame buffer at a requested screen position. Pixels whose colour matches the transparency key (12'h808) are skipped, and so are pixels that fall off-screen. Sits between game logic, which issues draw requests, and the frame-buffer write port. It replaces per-pixel combinational sprite lookup in the VGA path.

## Interface
- `SPR_W`, 21: sprite width in pixels.
- `SPR_H`, 21: sprite height; SPR_W*SPR_H ≤ 512.
- `SCR_W`, 640: screen width.
- `SCR_H`, 480: screen height.
- `KEY_COLOR`, 12'h808: transparent colour.
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  draw request, sampled only in IDLE.
- `sprite_x`  in  11  signed x of sprite top-left, latched on accepted start.
- `sprite_y`  in  11  signed y of sprite top-left, latched on accepted start.
- `flip`  in  1  horizontal mirror (left-facing sprite from right-facing ROM), latched on start.
- `busy`  out  1  high from accepted start until done.
- `done`  out  1  one-cycle completion pulse.
- `rom_addr`  out  9  ROM read address (to `read_address`).
- `rom_color`  in  12  ROM colour, combinational from `rom_addr` (from `output_color`).
- `fb_we`  out  1  frame-buffer write valid.
- `fb_addr`  out  19  y*SCR_W + x.
- `fb_data`  out  12  pixel colour.
- `fb_ready`  in  1  frame buffer accepts the write when `fb_we && fb_ready`.

## Operation
- States: IDLE, DRAW, DRAIN, DONE.
- IDLE: `start`=1 → latch x, y, flip; row=col=0; go to DRAW. `start` is ignored in every other state.
- DRAW: `rom_addr` = row*SPR_W + (flip ? SPR_W-1-col : col). The colour is sampled the same cycle.
  - If colour ≠ KEY_COLOR and 0 ≤ x+col < SCR_W and 0 ≤ y+row < SCR_H, the write register loads `fb_we`=1, `fb_addr`, `fb_data`. Otherwise it loads `fb_we`=0.
  - col increments and wraps at SPR_W-1, then row increments. After row=SPR_H-1, col=SPR_W-1 → DRAIN.
- Stall: while `fb_we && !fb_ready`, counters, `rom_addr`, the write register and the state all hold.
- DRAIN: waits until the write register is empty or accepted, then clears `fb_we` → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `busy` = state ≠ IDLE (includes DONE).
- Arithmetic:
  - Screen coordinates are 12-bit signed sums; a negative coordinate or one ≥ SCR dimension is clipped.
  - `fb_addr` is computed only for in-bounds pixels and is always < SCR_W*SCR_H.
- Reset, async, any state → IDLE. Counters cleared; `busy`, `done` and `fb_we` = 0; `rom_addr`, `fb_addr` and `fb_data` = 0. An in-flight write is dropped.

## Timing
- ROM read latency is 0; frame-buffer write latency is 1 cycle after the ROM address.
- No backpressure: `start` sampled at edge 0 → DRAW for 441 cycles → DRAIN 1 cycle → DONE 1 cycle. `done` is high in cycle 443. `busy` is high cycles 1–443.
- Each backpressure cycle adds exactly one cycle.
- Write ordering is raster order: rows top to bottom, screen x ascending (also when flipped).

## Configuration
- `SPRITE_FLIP_EN` defined: `flip` is honoured as above.
- `SPRITE_FLIP_EN` undefined: the mirror mux and flip register are removed. `flip` is ignored and `rom_addr` = row*SPR_W + col.

## Structure
- Shared package `sprite_pkg`:
  - state enum `blit_state_t`;
  - `SCR_W`/`SCR_H` and `KEY_COLOR` constants;
  - sprite dimension constants.
- One sub-module, `sprite_addr_gen`: row/col counters, wrap detection and mirrored ROM address.
- FSM, clipping and the write register stay in the top level.

## Test plan
- Fully opaque sprite at (0,0), `fb_ready`=1 → 441 writes, `fb_addr` 0..20, 640..660, …, 12800..12820; `done` in cycle 443.
- Model ROM with pal[0]=12'h808 on the border ring → only the 19×19 interior is written (361 writes); no `fb_data`=12'h808 ever appears.
- Sprite at (630,470) → 100 writes (10×10). Sprite at (-5,-3) → 16×18=288 writes, first `fb_addr`=0.
- `flip`=1 at (100,50): write at `fb_addr` 32100 carries ROM[20]. Without `SPRITE_FLIP_EN` it carries ROM[0].
- `fb_ready` toggled randomly at 50% → same write sequence as with ready=1; `rom_addr` stable during stalls; total cycles = 443 + stall count.
- `start` pulsed while busy → ignored. `Reset` at DRAW pixel 200 → `busy`/`fb_we`=0 immediately; the next start performs a clean full draw.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and FSM state type for the sprite blitter
package sprite_pkg;

   localparam int SPR_W = 21;
   localparam int SPR_H = 21;
   localparam int SPR_N = SPR_W * SPR_H;
   localparam int SCR_W = 640;
   localparam int SCR_H = 480;

   localparam logic [11:0] KEY_COLOR = 12'h808;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_DRAIN,
      S_DONE
   } blit_state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - sprite row/col walker and ROM address, mirror mux under SPRITE_FLIP_EN
module sprite_addr_gen
   import sprite_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       i_clear,
   input  logic       i_step,
   input  logic       i_flip,
   output logic [4:0] o_row,
   output logic [4:0] o_col,
   output logic       o_last,
   output logic [8:0] o_rom_addr
);

   logic [4:0] r_row;
   logic [4:0] r_col;
   logic       w_col_wrap;
   logic       w_row_wrap;
   logic [4:0] w_src_col;

   assign w_col_wrap = (r_col == 5'(SPR_W - 1));
   assign w_row_wrap = (r_row == 5'(SPR_H - 1));

   // Both counters return to zero after the final pixel so the next draw starts clean.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_step) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= w_row_wrap ? 5'd0 : r_row + 5'd1;
         end else begin
            r_col <= r_col + 5'd1;
         end
      end
   end

`ifdef SPRITE_FLIP_EN
   logic r_flip;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_flip <= 1'b0;
      end else if (i_clear) begin
         r_flip <= i_flip;
      end
   end

   assign w_src_col = r_flip ? (5'(SPR_W - 1) - r_col) : r_col;
`else
   logic w_unused_flip;

   assign w_unused_flip = i_flip;
   assign w_src_col     = r_col;
`endif

   assign o_row      = r_row;
   assign o_col      = r_col;
   assign o_last     = w_col_wrap && w_row_wrap;
   assign o_rom_addr = 9'(r_row) * 9'(SPR_W) + 9'(w_src_col);

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - draws a keyed, clipped 21x21 sprite into the frame buffer; SPRITE_FLIP_EN enables mirroring
module sprite_blitter
   import sprite_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [10:0] sprite_x,
   input  logic [10:0] sprite_y,
   input  logic        flip,
   output logic        busy,
   output logic        done,
   output logic [8:0]  rom_addr,
   input  logic [11:0] rom_color,
   output logic        fb_we,
   output logic [18:0] fb_addr,
   output logic [11:0] fb_data,
   input  logic        fb_ready
);

   blit_state_t r_state;
   blit_state_t w_next;

   logic [10:0] r_x;
   logic [10:0] r_y;
   logic        r_fb_we;
   logic [18:0] r_fb_addr;
   logic [11:0] r_fb_data;

   logic        w_accept;
   logic        w_stall;
   logic        w_step;
   logic        w_last;
   logic [4:0]  w_row;
   logic [4:0]  w_col;
   logic signed [11:0] w_sx;
   logic signed [11:0] w_sy;
   logic        w_in_x;
   logic        w_in_y;
   logic        w_visible;
   logic [18:0] w_pix_addr;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_stall  = r_fb_we && !fb_ready;
   assign w_step   = (r_state == S_DRAW) && !w_stall;

   sprite_addr_gen u_addr_gen (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_clear    (w_accept),
      .i_step     (w_step),
      .i_flip     (flip),
      .o_row      (w_row),
      .o_col      (w_col),
      .o_last     (w_last),
      .o_rom_addr (rom_addr)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_accept) begin
         r_x <= sprite_x;
         r_y <= sprite_y;
      end
   end

   // 12-bit signed screen coordinates; negative or past-the-edge pixels are clipped.
   assign w_sx      = $signed({r_x[10], r_x}) + $signed({7'd0, w_col});
   assign w_sy      = $signed({r_y[10], r_y}) + $signed({7'd0, w_row});
   assign w_in_x    = !w_sx[11] && (w_sx[10:0] < 11'(SCR_W));
   assign w_in_y    = !w_sy[11] && (w_sy[10:0] < 11'(SCR_H));
   assign w_visible = (rom_color != KEY_COLOR) && w_in_x && w_in_y;
   assign w_pix_addr = 19'(w_sy[8:0]) * 19'(SCR_W) + 19'(w_sx[9:0]);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_DRAW;
         S_DRAW:  if (w_step && w_last) w_next = S_DRAIN;
         S_DRAIN: if (!w_stall) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Address/data only reload for visible pixels; fb_we alone marks validity.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_fb_we   <= 1'b0;
         r_fb_addr <= '0;
         r_fb_data <= '0;
      end else if (w_step) begin
         r_fb_we <= w_visible;
         if (w_visible) begin
            r_fb_addr <= w_pix_addr;
            r_fb_data <= rom_color;
         end
      end else if ((r_state == S_DRAIN) && !w_stall) begin
         r_fb_we <= 1'b0;
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
   assign fb_we   = r_fb_we;
   assign fb_addr = r_fb_addr;
   assign fb_data = r_fb_data;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter with a model ROM
module tb_sprite_blitter;

`ifdef SPRITE_FLIP_EN
   localparam bit FLIP_EN = 1'b1;
`else
   localparam bit FLIP_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [10:0] sprite_x = '0;
   logic [10:0] sprite_y = '0;
   logic        flip = 1'b0;
   logic        busy;
   logic        done;
   logic [8:0]  rom_addr;
   logic [11:0] rom_color;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [11:0] fb_data;
   logic        fb_ready = 1'b1;

   logic [11:0] rom [0:440];

   typedef struct packed {
      logic [18:0] a;
      logic [11:0] d;
   } wr_t;

   wr_t exp_q[$];

   int n_checks = 0;
   int n_fail = 0;

   int          r_writes, r_cycles, r_stalls, r_bad, r_key_seen, r_rom_moves;
   int          probe_addr;
   logic [11:0] r_probe_data;
   logic [18:0] r_first_addr, r_last_addr;
   logic        r_busy1, r_timeout;
   wr_t         r_bad_got, r_bad_want;

   sprite_blitter dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .start     (start),
      .sprite_x  (sprite_x),
      .sprite_y  (sprite_y),
      .flip      (flip),
      .busy      (busy),
      .done      (done),
      .rom_addr  (rom_addr),
      .rom_color (rom_color),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_data   (fb_data),
      .fb_ready  (fb_ready)
   );

   assign rom_color = (rom_addr < 9'd441) ? rom[rom_addr] : 12'h000;

   always #5 Clk = ~Clk;

   task automatic load_opaque();
      for (int i = 0; i < 441; i++) rom[i] = 12'(i + 1);
   endtask

   task automatic load_border();
      for (int r = 0; r < 21; r++)
         for (int c = 0; c < 21; c++)
            rom[r*21+c] = (r == 0 || r == 20 || c == 0 || c == 20) ? 12'h808 : 12'(r*21 + c + 256);
   endtask

   task automatic load_random();
      for (int i = 0; i < 441; i++) begin
         logic [11:0] c;
         c = 12'($urandom);
         rom[i] = (c == 12'h808) ? 12'h123 : c;
      end
   endtask

   task automatic build_expected(input int x, input int y, input bit fl);
      exp_q.delete();
      for (int row = 0; row < 21; row++) begin
         for (int col = 0; col < 21; col++) begin
            int sx, sy, idx;
            logic [11:0] c;
            sx  = x + col;
            sy  = y + row;
            idx = row*21 + ((fl && FLIP_EN) ? 20 - col : col);
            c   = rom[idx];
            if (c != 12'h808 && sx >= 0 && sx < 640 && sy >= 0 && sy < 480)
               exp_q.push_back('{a: 19'(sy*640 + sx), d: c});
         end
      end
   endtask

   // Runs one draw, collecting accepted writes against the scoreboard.
   task automatic run_draw(input int x, input int y, input bit fl, input int ready_pct, input int restart_at);
      int  cyc;
      bit  done_seen, prev_stall;
      logic [8:0] prev_addr;
      wr_t w;
      build_expected(x, y, fl);
      r_writes = 0; r_cycles = 0; r_stalls = 0; r_bad = 0; r_key_seen = 0; r_rom_moves = 0;
      r_probe_data = 12'hxxx; r_first_addr = '1; r_last_addr = '1; r_busy1 = 1'b0;
      r_bad_got = '0; r_bad_want = '0;
      @(negedge Clk);
      sprite_x = 11'(x); sprite_y = 11'(y); flip = fl; start = 1'b1; fb_ready = 1'b1;
      cyc = 0; done_seen = 0; prev_stall = 0; prev_addr = '0;
      while (!done_seen && cyc < 4000) begin
         @(negedge Clk);
         cyc++;
         start = (cyc == restart_at);
         if (cyc == restart_at) begin
            sprite_x = 11'd300; sprite_y = 11'd300; flip = ~fl;
         end
         fb_ready = ($urandom_range(99) < ready_pct);
         #1;
         if (cyc == 1) r_busy1 = busy;
         if (prev_stall && rom_addr !== prev_addr) r_rom_moves++;
         prev_stall = fb_we && !fb_ready;
         prev_addr  = rom_addr;
         if (prev_stall) r_stalls++;
         if (fb_we && fb_ready) begin
            r_writes++;
            if (fb_data == 12'h808) r_key_seen++;
            if (r_writes == 1) r_first_addr = fb_addr;
            r_last_addr = fb_addr;
            if (fb_addr == 19'(probe_addr)) r_probe_data = fb_data;
            if (exp_q.size() == 0) begin
               if (r_bad == 0) begin r_bad_got = {fb_addr, fb_data}; r_bad_want = '0; end
               r_bad++;
            end else begin
               w = exp_q.pop_front();
               if (w.a !== fb_addr || w.d !== fb_data) begin
                  if (r_bad == 0) begin r_bad_got = {fb_addr, fb_data}; r_bad_want = w; end
                  r_bad++;
               end
            end
         end
         if (done) begin
            done_seen = 1;
            r_cycles  = cyc;
         end
      end
      r_bad     += exp_q.size();
      r_timeout = !done_seen;
      start     = 1'b0;
      fb_ready  = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      #12;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
      n_checks++; if (rom_addr !== 9'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
      n_checks++; if (fb_addr !== 19'd0) begin n_fail++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
      n_checks++; if (fb_data !== 12'd0) begin n_fail++; $display("FAIL reset_fb_data: got %h want 000", fb_data); end
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_opaque();
      load_opaque();
      probe_addr = -1;
      run_draw(0, 0, 1'b0, 100, 0);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL opaque_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_writes !== 441) begin n_fail++; $display("FAIL opaque_writes: got %0d want 441", r_writes); end
      n_checks++; if (r_timeout || r_cycles !== 443) begin n_fail++; $display("FAIL opaque_done_cycle: got %0d want 443", r_cycles); end
      n_checks++; if (r_first_addr !== 19'd0) begin n_fail++; $display("FAIL opaque_first_addr: got %0d want 0", r_first_addr); end
      n_checks++; if (r_last_addr !== 19'd12820) begin n_fail++; $display("FAIL opaque_last_addr: got %0d want 12820", r_last_addr); end
      n_checks++; if (r_busy1 !== 1'b1) begin n_fail++; $display("FAIL opaque_busy_c1: got %b want 1", r_busy1); end
      @(negedge Clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL opaque_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_transparent();
      load_border();
      probe_addr = -1;
      run_draw(200, 100, 1'b0, 100, 0);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL key_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_writes !== 361) begin n_fail++; $display("FAIL key_writes: got %0d want 361", r_writes); end
      n_checks++; if (r_key_seen !== 0) begin n_fail++; $display("FAIL key_color_written: got %0d want 0", r_key_seen); end
   endtask

   task automatic test_clip();
      load_opaque();
      probe_addr = -1;
      run_draw(630, 470, 1'b0, 100, 0);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL clip_br_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_writes !== 100) begin n_fail++; $display("FAIL clip_br_writes: got %0d want 100", r_writes); end
      run_draw(-5, -3, 1'b0, 100, 0);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL clip_tl_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_writes !== 288) begin n_fail++; $display("FAIL clip_tl_writes: got %0d want 288", r_writes); end
      n_checks++; if (r_first_addr !== 19'd0) begin n_fail++; $display("FAIL clip_tl_first: got %0d want 0", r_first_addr); end
   endtask

   task automatic test_flip();
      logic [11:0] want;
      load_random();
      want = FLIP_EN ? rom[20] : rom[0];
      probe_addr = 32100;
      run_draw(100, 50, 1'b1, 100, 0);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL flip_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_probe_data !== want) begin n_fail++; $display("FAIL flip_pixel: got %h want %h", r_probe_data, want); end
   endtask

   task automatic test_backpressure();
      load_random();
      probe_addr = -1;
      run_draw(37, 211, 1'b0, 50, 0);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL bp_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_writes !== 441) begin n_fail++; $display("FAIL bp_writes: got %0d want 441", r_writes); end
      n_checks++; if (r_timeout || r_cycles !== 443 + r_stalls) begin n_fail++; $display("FAIL bp_cycles: got %0d want %0d", r_cycles, 443 + r_stalls); end
      n_checks++; if (r_rom_moves !== 0) begin n_fail++; $display("FAIL bp_rom_stable: got %0d moves want 0", r_rom_moves); end
   endtask

   task automatic test_start_ignored();
      load_opaque();
      probe_addr = -1;
      run_draw(10, 20, 1'b0, 100, 100);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL restart_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_timeout || r_cycles !== 443) begin n_fail++; $display("FAIL restart_cycles: got %0d want 443", r_cycles); end
   endtask

   task automatic test_reset_mid_draw();
      logic we_before;
      load_opaque();
      @(negedge Clk);
      sprite_x = 11'd0; sprite_y = 11'd0; flip = 1'b0; start = 1'b1; fb_ready = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      repeat (199) @(negedge Clk);
      #1;
      we_before = fb_we;
      Reset = 1'b1;
      #1;
      n_checks++; if (we_before !== 1'b1) begin n_fail++; $display("FAIL mid_we_before: got %b want 1", we_before); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fb_we: got %b want 0", fb_we); end
      @(negedge Clk);
      Reset = 1'b0;
      probe_addr = -1;
      run_draw(0, 0, 1'b0, 100, 0);
      n_checks++; if (r_bad !== 0) begin n_fail++; $display("FAIL mid_redraw_sb: %0d bad, got %h want %h", r_bad, r_bad_got, r_bad_want); end
      n_checks++; if (r_writes !== 441) begin n_fail++; $display("FAIL mid_redraw_writes: got %0d want 441", r_writes); end
      n_checks++; if (r_timeout || r_cycles !== 443) begin n_fail++; $display("FAIL mid_redraw_cycles: got %0d want 443", r_cycles); end
   endtask

   initial begin
      test_reset();
      test_opaque();
      test_transparent();
      test_clip();
      test_flip();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_draw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
